// File: rtl/aes_pkg.sv
// Shared AES-128 types and byte-level helpers (S-box, round constants).
// The S-box is computed as GF(2^8) inversion followed by the AES affine map.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_KEY_W = 128;

  typedef logic [31:0]          aes_word_t;
  typedef logic [AES_KEY_W-1:0] aes_block_t;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} aes_state_t;

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x;
    x = gf_mul(gf_mul(a, a), a);
    for (int i = 0; i < 5; i++) x = gf_mul(gf_mul(x, x), a);
    return gf_mul(x, x);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic aes_word_t sub_word(input aes_word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// Combinational single-round AES-128 key expansion: previous round key plus
// round index in, next round key out (word0 in the top bits).
module aes_key_round
  import aes_pkg::*;
(
  input  aes_block_t  key_in,
  input  logic [3:0]  rnd,
  output aes_block_t  key_out
);

  aes_word_t w0, w1, w2, w3, t, n0, n1, n2, n3;

  assign w0 = key_in[127:96];
  assign w1 = key_in[95:64];
  assign w2 = key_in[63:32];
  assign w3 = key_in[31:0];

  assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rnd), 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_key_schedule_seq.sv
// Sequential AES-128 key schedule: expands one round key per clock into an
// 11-entry register file and serves them through a registered read port.
module aes128_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [127:0]     key_in,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic             rk_rd_en,
  input  logic [IDX_W-1:0] rk_rd_idx,
  output logic             rk_rd_vld,
  output logic [127:0]     rk_rd_data,
  output logic             rk_rd_err
);

  localparam logic [3:0]       LAST_RND = 4'(NUM_ROUNDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

  aes_state_t state_q, state_d;
  logic [3:0] rnd;
  aes_block_t rk [0:NUM_ROUNDS];
  aes_block_t prev_key, next_key, rd_sel;
  logic       accept, last_round, rd_legal;

  assign key_ready  = (state_q == IDLE || state_q == DONE) && !abort;
  assign accept     = key_valid && key_ready;
  assign busy       = (state_q == EXPAND);
  assign last_round = (state_q == EXPAND) && (rnd == LAST_RND);
  assign rd_legal   = keys_valid && (rk_rd_idx <= LAST_IDX);

  always_comb begin
    prev_key = rk[0];
    for (int i = 1; i <= NUM_ROUNDS; i++)
      if (rnd == 4'(i)) prev_key = rk[i-1];
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++)
      if (rk_rd_idx == IDX_W'(i)) rd_sel = rk[i];
  end

  aes_key_round u_round (
    .key_in  (prev_key),
    .rnd     (rnd),
    .key_out (next_key)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXPAND;
      EXPAND:  if (last_round) state_d = DONE;
      DONE:    if (accept) state_d = EXPAND;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd        <= '0;
      keys_valid <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      rnd        <= '0;
      keys_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= last_round;
      if (accept) begin
        rnd        <= 4'd1;
        keys_valid <= 1'b0;
      end else if (last_round) begin
        keys_valid <= 1'b1;
      end else if (state_q == EXPAND) begin
        rnd <= rnd + 4'd1;
      end
    end
  end

  // Aborted expansions leave partial contents behind; keys_valid gates reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
    end else if (accept) begin
      rk[0] <= key_in;
    end else if (state_q == EXPAND && !abort) begin
      for (int i = 1; i <= NUM_ROUNDS; i++)
        if (rnd == 4'(i)) rk[i] <= next_key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_rd_vld  <= 1'b0;
      rk_rd_err  <= 1'b0;
      rk_rd_data <= '0;
    end else begin
      rk_rd_vld <= rk_rd_en;
      rk_rd_err <= rk_rd_en && !rd_legal;
      if (rk_rd_en) rk_rd_data <= rd_legal ? rd_sel : '0;
    end
  end

endmodule

// File: tb/tb_aes128_key_schedule_seq.sv
// Scoreboard bench: a FIPS-197 style word-array key expansion model predicts
// status outputs and read responses; a negedge monitor compares the DUT.
module tb_aes128_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         abort;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_idx;
  logic         rk_rd_vld;
  logic [127:0] rk_rd_data;
  logic         rk_rd_err;

  aes128_key_schedule_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rk_rd_en   (rk_rd_en),
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_vld  (rk_rd_vld),
    .rk_rd_data (rk_rd_data),
    .rk_rd_err  (rk_rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic         err;
  } rd_t;

  int           checks   = 0;
  int           failures = 0;
  logic [7:0]   sb [256];
  logic [7:0]   rc [11];
  logic [127:0] m_rk [11];
  logic [127:0] m_next [11];
  logic [127:0] m_pend;
  logic [127:0] m_last;
  int           m_state;   // 0 idle, 1 expanding, 2 done
  int           m_cnt;
  logic         m_kv, m_done, m_rvld;
  rd_t          rq [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box via the multiplicative generator walk (p *= 3, q /= 3)
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int i = 2; i <= 10; i++)
      rc[i] = {rc[i-1][6:0], 1'b0} ^ (rc[i-1][7] ? 8'h1b : 8'h00);
  endtask

  task automatic expand_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_next[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_kv    = 1'b0;
    m_done  = 1'b0;
    m_rvld  = 1'b0;
    m_last  = '0;
    rq.delete();
    for (int i = 0; i < 11; i++) m_rk[i] = '0;
  endtask

  task automatic model_edge();
    rd_t r;
    logic ready;
    m_rvld = rk_rd_en;
    if (rk_rd_en) begin
      r.data = '0;
      r.err  = 1'b1;
      if (m_kv && rk_rd_idx <= 4'd10) begin
        r.data = m_rk[rk_rd_idx];
        r.err  = 1'b0;
      end
      rq.push_back(r);
      m_last = r.data;
    end
    ready  = (m_state != 1) && !abort;
    m_done = 1'b0;
    if (abort) begin
      m_state = 0;
      m_kv    = 1'b0;
      m_cnt   = 0;
    end else if (key_valid && ready) begin
      m_state = 1;
      m_cnt   = 10;
      m_kv    = 1'b0;
      m_pend  = key_in;
    end else if (m_state == 1) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_state = 2;
        m_kv    = 1'b1;
        m_done  = 1'b1;
        expand_key(m_pend);
        m_rk = m_next;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic quiet();
    key_valid = 1'b0;
    abort     = 1'b0;
    rk_rd_en  = 1'b0;
    rk_rd_idx = '0;
  endtask

  task automatic load(input logic [127:0] k);
    key_valid = 1'b1;
    key_in    = k;
    step();
    key_valid = 1'b0;
  endtask

  task automatic rd(input int idx);
    rk_rd_en  = 1'b1;
    rk_rd_idx = 4'(idx);
    step();
    rk_rd_en  = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_key_ready"}, key_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_keys_valid"}, keys_valid, 1'b0);
    chk({tag, "_rd_vld"}, rk_rd_vld, 1'b0);
    chk({tag, "_rd_err"}, rk_rd_err, 1'b0);
    chk({tag, "_rd_data"}, rk_rd_data, '0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      rd_t e;
      chk("busy", busy, m_state == 1);
      chk("done", done, m_done);
      chk("keys_valid", keys_valid, m_kv);
      chk("key_ready", key_ready, (m_state != 1) && !abort);
      chk("rd_vld", rk_rd_vld, m_rvld);
      if (rk_rd_vld) begin
        if (rq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected actual=%h expected=no_read", rk_rd_data);
        end else begin
          e = rq.pop_front();
          chk("rd_data", rk_rd_data, e.data);
          chk("rd_err", rk_rd_err, e.err);
        end
      end else begin
        chk("rd_hold", rk_rd_data, m_last);
      end
    end
  end

  initial begin
    build_tables();
    model_reset();
    quiet();
    key_in = '0;
    rst_n  = 1'b0;

    // Model anchored to the published vectors
    expand_key(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    chk("model_k1_rk1", m_next[1], 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    chk("model_k1_rk10", m_next[10], 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    expand_key('0);
    chk("model_k0_rk1", m_next[1], {4{32'h62636363}});
    chk("model_k0_rk10", m_next[10], 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e);

    #2;
    chk_reset_outputs("por");
    #21 rst_n = 1'b1;
    step();
    rd(3);
    step();

    // Test 1: FIPS key, full read-back
    load(128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    repeat (11) step();
    for (int i = 0; i <= 10; i++) begin
      rk_rd_en  = 1'b1;
      rk_rd_idx = 4'(i);
      step();
    end
    rk_rd_en = 1'b0;

    // Test 4: out-of-range indices with keys valid
    rd(11);
    rd(15);
    step();

    // Test 2: zero key
    load('0);
    repeat (11) step();
    rd(1);
    rd(10);

    // Test 5: re-key in DONE while reading idx 10 in the same cycle
    key_valid = 1'b1;
    key_in    = 128'h00112233_44556677_8899aabb_ccddeeff;
    rk_rd_en  = 1'b1;
    rk_rd_idx = 4'd10;
    step();
    quiet();
    repeat (11) step();
    rd(10);
    rd(0);

    // key_valid during expansion must be ignored
    load(128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0);
    for (int i = 0; i < 8; i++) begin
      key_valid = 1'b1;
      key_in    = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    key_valid = 1'b0;
    repeat (4) step();
    rd(10);

    // Test 3: abort mid-expansion
    load(128'hdeadbeef_01234567_89abcdef_cafef00d);
    repeat (4) step();
    abort     = 1'b1;
    key_valid = 1'b1;
    step();
    quiet();
    rd(3);
    repeat (12) step();

    // Test 6: asynchronous reset mid-expansion
    load(128'h13579bdf_2468ace0_0f0f0f0f_f0f0f0f0);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    step();
    #2 rst_n = 1'b1;
    step();

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      key_valid = ($urandom_range(0, 5) == 0);
      key_in    = {$urandom, $urandom, $urandom, $urandom};
      abort     = ($urandom_range(0, 60) == 0);
      rk_rd_en  = $urandom_range(0, 1) == 1;
      rk_rd_idx = 4'($urandom_range(0, 15));
      step();
    end
    quiet();
    repeat (3) step();
    chk("scoreboard_drained", 128'(rq.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
